// File: rtl/fifo_axis_reader.sv
// Drains a registered-read FIFO into an AXI4-Stream master through a 3-entry skid buffer.
// Read issue depends only on registered occupancy, so fifo_rd_en never sees m_axis_tready.
module fifo_axis_reader #(
   parameter int B  = 160,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          fifo_rd_en,
   input  logic [B-1:0]  fifo_dout,
   input  logic          fifo_empty,
   output logic [B-1:0]  m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          busy,
   output logic [CW-1:0] xfer_cnt
);

   logic [B-1:0]  mem_q [3];
   logic [B-1:0]  mem_d [3];
   logic [1:0]    occ_q, occ_d;
   logic [1:0]    head_q, head_d;
   logic [1:0]    tail_q, tail_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] xfer_q, xfer_d;
   logic          cap;
   logic          pop;

   function automatic logic [1:0] inc3(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   always_comb begin
      // Reads are allowed while words held plus the word in flight leave a free slot.
      fifo_rd_en = !rst && en && !fifo_empty &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);
      cap        = inflight_q;
      pop        = (occ_q != 2'd0) && m_axis_tready;

      mem_d      = mem_q;
      tail_d     = tail_q;
      head_d     = head_q;
      if (cap) begin
         mem_d[tail_q] = fifo_dout;
         tail_d        = inc3(tail_q);
      end
      if (pop) begin
         head_d = inc3(head_q);
      end
      occ_d      = occ_q + {1'b0, cap} - {1'b0, pop};
      inflight_d = fifo_rd_en;
      xfer_d     = xfer_q + {{(CW-1){1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            mem_q[i] <= '0;
         end
         occ_q      <= 2'd0;
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         inflight_q <= 1'b0;
         xfer_q     <= '0;
      end else begin
         mem_q      <= mem_d;
         occ_q      <= occ_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         inflight_q <= inflight_d;
         xfer_q     <= xfer_d;
      end
   end

   assign m_axis_tvalid = (occ_q != 2'd0);
   assign m_axis_tdata  = mem_q[head_q];
   assign busy          = (occ_q != 2'd0) || inflight_q;
   assign xfer_cnt      = xfer_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: behavioural FIFO, outstanding-word reference model, directed and random traffic.
// A second instance with a 4-bit counter shares the stimulus to observe counter wrap.
module tb_fifo_axis_reader;

   localparam int B = 160;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          tready = 1'b0;
   logic          wr_en = 1'b0;
   logic [B-1:0]  wr_data = '0;
   logic [B-1:0]  fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          rd_en, rd_en4;
   logic [B-1:0]  tdata, tdata4;
   logic          tvalid, tvalid4;
   logic          busy, busy4;
   logic [31:0]   xfer;
   logic [3:0]    xfer4;

   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   fifo_axis_reader #(.B(B), .CW(32)) u_dut (
      .clk(clk), .rst(rst), .en(en), .fifo_rd_en(rd_en), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .busy(busy), .xfer_cnt(xfer)
   );

   fifo_axis_reader #(.B(B), .CW(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .fifo_rd_en(rd_en4), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4),
      .m_axis_tready(tready), .busy(busy4), .xfer_cnt(xfer4)
   );

   task automatic chk(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Behavioural FIFO with a one-cycle registered read, reset together with the DUT.
   logic [B-1:0] fq [$];
   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         fifo_dout <= '0;
      end else begin
         if (rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   // Reference: words read but not yet handed off, the last-cycle read flag, and the stream order.
   int           rd_cnt = 0;
   int           pop_cnt = 0;
   int           hs_cnt = 0;
   bit           last_acc = 1'b0;
   logic [B-1:0] exp_q [$];

   initial begin
      forever begin
         int  outstanding, occ;
         bit  exp_rd, exp_pop;
         @(negedge clk);
         outstanding = rd_cnt - pop_cnt;
         occ         = outstanding - int'(last_acc);
         exp_rd      = !rst && en && !fifo_empty && (outstanding <= 2);
         chk("rd_en", B'(rd_en), B'(exp_rd));
         chk("rd_en4", B'(rd_en4), B'(exp_rd));
         exp_pop = 1'b0;
         if (!rst) begin
            chk("tvalid", B'(tvalid), B'(occ != 0));
            chk("tvalid4", B'(tvalid4), B'(occ != 0));
            chk("busy", B'(busy), B'(outstanding != 0));
            chk("busy4", B'(busy4), B'(outstanding != 0));
            chk("xfer_cnt", B'(xfer), B'(hs_cnt));
            chk("xfer_cnt4", B'(xfer4), B'(hs_cnt % 16));
            if (occ != 0) begin
               if (exp_q.size() == 0) begin
                  chk("model_underrun", B'(exp_q.size()), B'(1));
               end else begin
                  chk("tdata", tdata, exp_q[0]);
                  chk("tdata4", tdata4, exp_q[0]);
               end
            end
            exp_pop = (occ != 0) && tready;
         end
         if (rst) begin
            rd_cnt   = 0;
            pop_cnt  = 0;
            hs_cnt   = 0;
            last_acc = 1'b0;
            exp_q.delete();
         end else begin
            if (exp_pop) begin
               pop_cnt++;
               hs_cnt++;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (exp_rd) rd_cnt++;
            last_acc = exp_rd;
            if (wr_en) exp_q.push_back(wr_data);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [B-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push(input logic [B-1:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!tvalid && n < budget) begin
         tick();
         n++;
      end
      chk(tag, B'(tvalid), B'(1));
   endtask

   logic [B-1:0] words [8];
   logic [B-1:0] fresh;
   int           pushed;
   int           guard;

   initial begin
      // Reset state
      do_reset();
      chk("rst_tvalid", B'(tvalid), B'(0));
      chk("rst_tdata", tdata, B'(0));
      chk("rst_busy", B'(busy), B'(0));
      chk("rst_xfer", B'(xfer), B'(0));
      chk("rst_rd_en", B'(rd_en), B'(0));

      // Streaming 0x1..0x10
      tready = 1'b1;
      for (int i = 1; i <= 16; i++) push(B'(i));
      en = 1'b1;
      wait_valid("stream_start", 10);
      for (int i = 1; i <= 16; i++) begin
         chk("stream_valid", B'(tvalid), B'(1));
         chk("stream_data", tdata, B'(i));
         tick();
      end
      chk("stream_xfer", B'(xfer), B'(16));
      chk("stream_xfer4", B'(xfer4), B'(0));
      chk("stream_busy", B'(busy), B'(0));

      // Backpressure
      en = 1'b0;
      tready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         words[i] = rnd_word();
         push(words[i]);
      end
      en = 1'b1;
      repeat (10) tick();
      chk("bp_reads", B'(rd_cnt), B'(3));
      chk("bp_occ", B'(rd_cnt - pop_cnt), B'(3));
      chk("bp_valid", B'(tvalid), B'(1));
      chk("bp_hold", tdata, words[0]);
      repeat (5) tick();
      chk("bp_hold_late", tdata, words[0]);
      tready = 1'b1;
      repeat (14) tick();
      chk("bp_count", B'(hs_cnt), B'(8));
      chk("bp_busy", B'(busy), B'(0));

      // Reset with a full skid buffer
      en = 1'b0;
      tready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) push(rnd_word());
      en = 1'b1;
      repeat (6) tick();
      chk("mid_full", B'(rd_cnt - pop_cnt), B'(3));
      do_reset();
      chk("mid_tvalid", B'(tvalid), B'(0));
      chk("mid_xfer", B'(xfer), B'(0));
      chk("mid_busy", B'(busy), B'(0));
      fresh = rnd_word();
      tready = 1'b1;
      push(fresh);
      wait_valid("mid_restart", 10);
      chk("mid_first", tdata, fresh);
      tick();

      // en drop after the first read
      en = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) push(rnd_word());
      en = 1'b1;
      tick();
      tick();
      en = 1'b0;
      repeat (10) tick();
      chk("endrop_count_ok", B'(hs_cnt >= 1 && hs_cnt <= 2), B'(1));
      chk("endrop_left", B'(fq.size() + hs_cnt), B'(6));
      chk("endrop_busy", B'(busy), B'(0));

      // Counter wrap on the 4-bit instance
      do_reset();
      en = 1'b1;
      tready = 1'b1;
      for (int i = 0; i < 17; i++) push(rnd_word());
      repeat (10) tick();
      chk("wrap_xfer4", B'(xfer4), B'(1));
      chk("wrap_xfer", B'(xfer), B'(17));

      // Random throttle, 10000 words
      do_reset();
      en = 1'b1;
      pushed = 0;
      while (pushed < 10000) begin
         tready = ($urandom_range(3) != 0);
         if ($urandom_range(1) == 1) begin
            wr_en   = 1'b1;
            wr_data = rnd_word();
            pushed++;
         end else begin
            wr_en = 1'b0;
         end
         tick();
      end
      wr_en = 1'b0;
      guard = 0;
      while (hs_cnt < 10000 && guard < 20000) begin
         tready = ($urandom_range(3) != 0);
         tick();
         guard++;
      end
      tready = 1'b1;
      repeat (4) tick();
      chk("rand_count", B'(hs_cnt), B'(10000));
      chk("rand_busy", B'(busy), B'(0));
      chk("rand_xfer", B'(xfer), B'(10000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
